// File: rtl/fsm_seq_pkg.sv
// Shared types and constants for the FSM-equivalence sequencer.
// Controller states, symbol/output widths and the shared FSM state codes.
package fsm_seq_pkg;

  localparam int unsigned SYM_W     = 2;
  localparam int unsigned FSM_OUT_W = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLR   = 2'd1,
    ST_RUN   = 2'd2,
    ST_DRAIN = 2'd3
  } ctrl_state_e;

  typedef enum logic [FSM_OUT_W-1:0] {
    FS_S0 = 3'd0,
    FS_S1 = 3'd1,
    FS_S2 = 3'd2,
    FS_S3 = 3'd3,
    FS_S4 = 3'd4,
    FS_S5 = 3'd5,
    FS_S6 = 3'd6
  } fsm_code_e;

  typedef logic [SYM_W-1:0]     sym_t;
  typedef logic [FSM_OUT_W-1:0] fsm_out_t;

  // True when all three FSM implementations report the same state.
  function automatic logic outs_agree(fsm_out_t a, fsm_out_t b, fsm_out_t c);
    return (a == b) && (b == c);
  endfunction

endpackage

// File: rtl/fsm_sequencer_buffer.sv
// Program buffer: DEPTH x 2-bit register array, one write port and
// a combinational read at an arbitrary index.
module seq_buffer
  import fsm_seq_pkg::*;
#(
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  sym_t                     wdata_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output sym_t                     rdata_o
);

  sym_t mem_q [DEPTH];

  // Contents need no reset; only indices below count are ever replayed.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/fsm_sequencer.sv
// Replays a stored symbol program into three FSM implementations and
// cross-checks their outputs; the checker exists only with FSMSEQ_CHECK_EN.
module fsm_sequencer
  import fsm_seq_pkg::*;
#(
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clr,
  input  logic                     wr_en,
  input  logic [SYM_W-1:0]         wr_sym,
  input  logic                     start,
  input  logic                     abort,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     busy,
  output logic                     done,
  output logic [SYM_W-1:0]         fsm_a,
  output logic                     fsm_rst_n,
  input  logic [FSM_OUT_W-1:0]     s_case,
  input  logic [FSM_OUT_W-1:0]     s_mem,
  input  logic [FSM_OUT_W-1:0]     s_gate,
  output logic                     mismatch,
  output logic [$clog2(DEPTH)-1:0] err_step,
  output logic [FSM_OUT_W-1:0]     final_state
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  ctrl_state_e    state_q, state_d;
  logic [CW-1:0]  count_q, count_d;
  logic [AW-1:0]  step_q, step_d;
  sym_t           fsm_a_q, fsm_a_d;
  logic           rst_n_q, rst_n_d;
  logic           done_q, done_d;
  logic           full_q, full_d;
  logic           busy_q, busy_d;
  fsm_out_t       final_q, final_d;
  logic           wr_do;
  logic [AW-1:0]  rd_idx;
  sym_t           rd_sym;

  seq_buffer #(
    .DEPTH(DEPTH)
  ) u_buf (
    .clk    (clk),
    .we_i   (wr_do),
    .waddr_i(count_q[AW-1:0]),
    .wdata_i(wr_sym),
    .raddr_i(rd_idx),
    .rdata_o(rd_sym)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      step_q  <= '0;
      fsm_a_q <= '0;
      rst_n_q <= 1'b0;
      done_q  <= 1'b0;
      full_q  <= 1'b0;
      busy_q  <= 1'b0;
      final_q <= FS_S0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      step_q  <= step_d;
      fsm_a_q <= fsm_a_d;
      rst_n_q <= rst_n_d;
      done_q  <= done_d;
      full_q  <= full_d;
      busy_q  <= busy_d;
      final_q <= final_d;
    end
  end

  // Next state and next registered outputs; outputs describe the state being entered.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    step_d  = step_q;
    fsm_a_d = fsm_a_q;
    rst_n_d = 1'b1;
    done_d  = 1'b0;
    final_d = final_q;
    wr_do   = 1'b0;
    rd_idx  = '0;

    case (state_q)
      ST_IDLE: begin
        fsm_a_d = '0;
        if (start && (count_q != '0)) begin
          state_d = ST_CLR;
          step_d  = '0;
          rst_n_d = 1'b0;
          final_d = FS_S0;
        end else if (clr) begin
          count_d = '0;
        end else if (wr_en && !full_q) begin
          wr_do   = 1'b1;
          count_d = count_q + CW'(1);
        end
      end
      ST_CLR: begin
        if (abort) begin
          state_d = ST_IDLE;
          rst_n_d = 1'b0;
          fsm_a_d = '0;
        end else begin
          state_d = ST_RUN;
          step_d  = '0;
          fsm_a_d = rd_sym;
        end
      end
      ST_RUN: begin
        if (abort) begin
          state_d = ST_IDLE;
          rst_n_d = 1'b0;
          fsm_a_d = '0;
        end else if ((CW'(step_q) + CW'(1)) == count_q) begin
          state_d = ST_DRAIN;
        end else begin
          step_d  = step_q + AW'(1);
          rd_idx  = step_q + AW'(1);
          fsm_a_d = rd_sym;
        end
      end
      ST_DRAIN: begin
        state_d = ST_IDLE;
        fsm_a_d = '0;
        if (abort) begin
          rst_n_d = 1'b0;
        end else begin
          done_d  = 1'b1;
          final_d = s_case;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    full_d = (count_d == CW'(DEPTH));
    busy_d = (state_d != ST_IDLE);
  end

  assign count       = count_q;
  assign full        = full_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign fsm_a       = fsm_a_q;
  assign fsm_rst_n   = rst_n_q;
  assign final_state = final_q;

`ifdef FSMSEQ_CHECK_EN
  logic          cmp_en;
  logic [AW-1:0] cmp_idx;
  logic          mis_q, mis_d;
  logic [AW-1:0] err_q, err_d;

  // FSM outputs lag the stimulus by one edge, so the examined symbol is one behind.
  always_comb begin
    cmp_en  = 1'b0;
    cmp_idx = step_q - AW'(1);
    if (!abort) begin
      if ((state_q == ST_RUN) && (step_q != '0)) begin
        cmp_en = 1'b1;
      end
      if (state_q == ST_DRAIN) begin
        cmp_en  = 1'b1;
        cmp_idx = AW'(count_q - CW'(1));
      end
    end
  end

  always_comb begin
    mis_d = mis_q;
    err_d = err_q;
    if ((state_q == ST_IDLE) && (state_d == ST_CLR)) begin
      mis_d = 1'b0;
      err_d = '0;
    end else if (cmp_en && !outs_agree(s_case, s_mem, s_gate)) begin
      mis_d = 1'b1;
      if (!mis_q) begin
        err_d = cmp_idx;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mis_q <= 1'b0;
      err_q <= '0;
    end else begin
      mis_q <= mis_d;
      err_q <= err_d;
    end
  end

  assign mismatch = mis_q;
  assign err_step = err_q;
`else
  logic unused_s;
  assign unused_s = ^{s_mem, s_gate};
  assign mismatch = 1'b0;
  assign err_step = '0;
`endif

endmodule

// File: tb/tb_fsm_sequencer.sv
// Self-checking bench for fsm_sequencer: run-level reference model plus
// directed scenarios and randomized stimulus.
module tb_fsm_sequencer;

  localparam int DEPTH = 16;
  localparam int AW    = $clog2(DEPTH);
`ifdef FSMSEQ_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic          clk;
  logic          reset;
  logic          clr;
  logic          wr_en;
  logic [1:0]    wr_sym;
  logic          start;
  logic          abort;
  logic [AW:0]   count;
  logic          full;
  logic          busy;
  logic          done;
  logic [1:0]    fsm_a;
  logic          fsm_rst_n;
  logic [2:0]    s_case;
  logic [2:0]    s_mem;
  logic [2:0]    s_gate;
  logic          mismatch;
  logic [AW-1:0] err_step;
  logic [2:0]    final_state;

  fsm_sequencer #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .clr(clr), .wr_en(wr_en), .wr_sym(wr_sym),
    .start(start), .abort(abort), .count(count), .full(full), .busy(busy),
    .done(done), .fsm_a(fsm_a), .fsm_rst_n(fsm_rst_n), .s_case(s_case),
    .s_mem(s_mem), .s_gate(s_gate), .mismatch(mismatch), .err_step(err_step),
    .final_state(final_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: position within a run (-1 idle, 0 clear, 1..N steps, N+1 drain).
  int m_count, m_pos, m_err, m_final;
  bit m_mis, m_done, m_rst_low;
  int prog [DEPTH];

  int n_vec, n_err;
  int obs_busy, obs_done;
  int obs_a [$];
  int lit_a [6] = '{0, 2, 3, 1, 0, 0};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int exp_a();
    if (m_pos <= 0) return 0;
    if (m_pos <= m_count) return prog[m_pos-1];
    return prog[m_count-1];
  endfunction

  task automatic model_reset();
    m_pos = -1; m_count = 0; m_mis = 0; m_err = 0; m_final = 0;
    m_done = 0; m_rst_low = 1;
  endtask

  task automatic model_step(input bit st, input bit ab, input bit cl, input bit we,
                            input int sym, input int sc, input int sm, input int sg);
    m_done = 0;
    m_rst_low = 0;
    if (m_pos < 0) begin
      if (st && m_count > 0) begin
        m_pos = 0; m_mis = 0; m_err = 0; m_final = 0;
      end else if (cl) begin
        m_count = 0;
      end else if (we && m_count < DEPTH) begin
        prog[m_count] = sym;
        m_count++;
      end
    end else if (ab) begin
      m_pos = -1;
      m_rst_low = 1;
    end else begin
      if (m_pos >= 2 && !(sc == sm && sm == sg)) begin
        if (!m_mis) m_err = m_pos - 2;
        m_mis = 1;
      end
      if (m_pos == m_count + 1) begin
        m_final = sc; m_pos = -1; m_done = 1;
      end else begin
        m_pos++;
      end
    end
  endtask

  task automatic compare_all();
    chk("count", count, m_count);
    chk("full", full, (m_count == DEPTH) ? 1 : 0);
    chk("busy", busy, (m_pos >= 0) ? 1 : 0);
    chk("done", done, m_done);
    chk("fsm_a", fsm_a, exp_a());
    chk("fsm_rst_n", fsm_rst_n, (m_pos == 0 || m_rst_low) ? 0 : 1);
    chk("mismatch", mismatch, CHK ? m_mis : 0);
    chk("err_step", err_step, CHK ? m_err : 0);
    chk("final_state", final_state, m_final);
    if (busy === 1'b1) begin
      obs_busy++;
      obs_a.push_back(int'(fsm_a));
    end
    if (done === 1'b1) obs_done++;
  endtask

  task automatic cycle(input bit st, input bit ab, input bit cl, input bit we,
                       input int sym, input int sc, input int sm, input int sg);
    compare_all();
    start = st; abort = ab; clr = cl; wr_en = we; wr_sym = 2'(sym);
    s_case = 3'(sc); s_mem = 3'(sm); s_gate = 3'(sg);
    model_step(st, ab, cl, we, sym, sc, sm, sg);
    @(negedge clk);
  endtask

  task automatic idle(input int n, input int s);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, s, s, s);
  endtask

  task automatic clear_obs();
    obs_busy = 0; obs_done = 0; obs_a.delete();
  endtask

  task automatic write_prog_2310(input int s);
    cycle(0, 0, 0, 1, 2, s, s, s);
    cycle(0, 0, 0, 1, 3, s, s, s);
    cycle(0, 0, 0, 1, 1, s, s, s);
    cycle(0, 0, 0, 1, 0, s, s, s);
  endtask

  task automatic check_trace_2310(input string tag);
    chk({tag, "_busy_len"}, obs_busy, 6);
    chk({tag, "_done_cnt"}, obs_done, 1);
    for (int i = 0; i < 6; i++)
      chk({tag, "_fsm_a"}, (i < obs_a.size()) ? obs_a[i] : 32'hFFFF_FFFF, lit_a[i]);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    start = 0; abort = 0; clr = 0; wr_en = 0; wr_sym = 0;
    s_case = 0; s_mem = 0; s_gate = 0;
    model_reset();
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    n_vec = 0; n_err = 0;
    reset = 1'b0;
    #1;
    do_reset();
    chk("rst_busy", busy, 0);
    chk("rst_rstn", fsm_rst_n, 0);
    chk("rst_count", count, 0);

    // Basic run of 2,3,1,0 with agreeing FSM outputs.
    write_prog_2310(3);
    clear_obs();
    cycle(1, 0, 0, 0, 0, 3, 3, 3);
    idle(8, 3);
    check_trace_2310("run1");
    chk("run1_mismatch", mismatch, 0);
    chk("run1_final", final_state, 3);
    chk("idle_rstn", fsm_rst_n, 1);

    // Same program replayed; s_gate disagrees while symbol 2 is examined.
    cycle(1, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) cycle(0, 0, 0, 0, 0, 0, 0, (m_pos == 4) ? 5 : 0);
    chk("inj_mismatch", mismatch, CHK ? 1 : 0);
    chk("inj_err_step", err_step, CHK ? 2 : 0);
    idle(3, 0);
    chk("inj_mismatch_hold", mismatch, CHK ? 1 : 0);
    cycle(1, 0, 0, 0, 0, 0, 0, 0);
    chk("clr_mismatch", mismatch, 0);
    chk("clr_err_step", err_step, 0);
    idle(8, 0);

    // Start on an empty program is ignored.
    cycle(0, 0, 1, 1, 2, 0, 0, 0);
    clear_obs();
    cycle(1, 0, 0, 0, 0, 0, 0, 0);
    idle(4, 0);
    chk("empty_busy", obs_busy, 0);
    chk("empty_done", obs_done, 0);
    chk("empty_count", count, 0);

    // Overfill by one, then replay the full buffer.
    for (int i = 0; i < DEPTH + 1; i++) cycle(0, 0, 0, 1, $urandom_range(0, 3), 1, 1, 1);
    chk("full_count", count, DEPTH);
    chk("full_flag", full, 1);
    cycle(1, 0, 0, 0, 0, 1, 1, 1);
    for (int i = 0; i < DEPTH + 4; i++) begin
      int s = $urandom_range(0, 6);
      cycle(0, 0, 0, 0, 0, s, s, s);
    end

    // Abort in the third RUN cycle, then replay.
    do_reset();
    write_prog_2310(2);
    clear_obs();
    cycle(1, 0, 0, 0, 0, 2, 2, 2);
    idle(3, 2);
    cycle(0, 1, 0, 0, 0, 2, 2, 2);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_count", count, 4);
    chk("abort_rstn", fsm_rst_n, 0);
    idle(2, 2);
    chk("abort_no_done", obs_done, 0);
    clear_obs();
    cycle(1, 0, 0, 0, 0, 2, 2, 2);
    idle(8, 2);
    check_trace_2310("replay");

    // Reset pulsed mid-RUN takes effect without a clock edge.
    cycle(1, 0, 0, 0, 0, 4, 4, 4);
    idle(3, 4);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_count", count, 0);
    chk("arst_done", done, 0);
    chk("arst_fsm_a", fsm_a, 0);
    chk("arst_rstn", fsm_rst_n, 0);
    chk("arst_mismatch", mismatch, 0);
    chk("arst_err_step", err_step, 0);
    chk("arst_final", final_state, 0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    clear_obs();
    idle(4, 0);
    chk("arst_no_done", obs_done, 0);

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      bit st, ab, cl, we;
      int sym, sc, sm, sg;
      st  = ($urandom_range(0, 5) == 0);
      we  = $urandom_range(0, 1) == 1;
      cl  = ($urandom_range(0, 24) == 0);
      ab  = ($urandom_range(0, 15) == 0) && !(m_pos > m_count);
      sym = $urandom_range(0, 3);
      sc  = $urandom_range(0, 6);
      sm  = sc;
      sg  = sc;
      if (!ab && $urandom_range(0, 9) == 0) begin
        if ($urandom_range(0, 1) == 1) sm = (sc + 1) % 7;
        else sg = (sc + 3) % 7;
      end
      cycle(st, ab, cl, we, sym, sc, sm, sg);
    end
    compare_all();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
